// File: rtl/pong_pkg.sv
// Shared constants and types for the sprite layer mixer.
package pong_pkg;

  localparam int unsigned MODE_OR     = 0;
  localparam int unsigned MODE_PRIO   = 1;
  localparam int unsigned FRAME_CNT_W = 16;

  typedef enum logic {
    StIdle,
    StAccum
  } mix_state_e;

endpackage

// File: rtl/layer_prio_sel.sv
// Lowest-index-wins colour select across sprite layers.
module layer_prio_sel #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned COLOR_W    = 8
) (
  input  logic [NUM_LAYERS-1:0]         active_i,
  input  logic [NUM_LAYERS*COLOR_W-1:0] r_i,
  input  logic [NUM_LAYERS*COLOR_W-1:0] g_i,
  input  logic [NUM_LAYERS*COLOR_W-1:0] b_i,
  output logic [COLOR_W-1:0]            r_o,
  output logic [COLOR_W-1:0]            g_o,
  output logic [COLOR_W-1:0]            b_o
);

  logic [NUM_LAYERS-1:0] grant;

  // Scan from the top so the lowest active index is the last one kept.
  always_comb begin
    grant = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (active_i[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

  always_comb begin
    r_o = '0;
    g_o = '0;
    b_o = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (grant[i]) begin
        r_o = r_o | r_i[i*COLOR_W +: COLOR_W];
        g_o = g_o | g_i[i*COLOR_W +: COLOR_W];
        b_o = b_o | b_i[i*COLOR_W +: COLOR_W];
      end
    end
  end

endmodule

// File: rtl/layer_mixer.sv
// Sprite layer mixer: registered per-pixel colour blend plus per-frame collision reporting.
module layer_mixer
  import pong_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned COLOR_W    = 8,
  parameter int unsigned MODE       = MODE_OR
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          vsync,
  input  logic [NUM_LAYERS-1:0]         layer_hit,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_r,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_g,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_b,
  input  logic [NUM_LAYERS-1:0]         layer_en,
  input  logic [NUM_LAYERS-1:0]         coll_mask,
  input  logic                          irq_ack,
  output logic [COLOR_W-1:0]            out_r,
  output logic [COLOR_W-1:0]            out_g,
  output logic [COLOR_W-1:0]            out_b,
  output logic [NUM_LAYERS-1:0]         coll_flags,
  output logic                          frame_tick,
  output logic                          coll_irq,
  output logic [FRAME_CNT_W-1:0]        frame_cnt
);

  mix_state_e state_q, state_d;

  logic                   vsync_q;
  logic [NUM_LAYERS-1:0]  acc_q, acc_d;
  logic [NUM_LAYERS-1:0]  flags_q, flags_d;
  logic                   tick_q, tick_d;
  logic                   irq_q, irq_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [COLOR_W-1:0]     out_r_q, out_g_q, out_b_q;

  logic [NUM_LAYERS-1:0]  active, coll, contrib, closing;
  logic [COLOR_W-1:0]     mix_r, mix_g, mix_b;
  logic                   multi, vsync_fall, boundary;

  assign active     = layer_hit & layer_en;
  assign coll       = layer_hit & coll_mask;
  // Clearing the lowest set bit leaves something only when two or more bits are set.
  assign multi      = |(coll & (coll - NUM_LAYERS'(1)));
  assign contrib    = multi ? coll : '0;
  assign closing    = acc_q | contrib;
  assign vsync_fall = vsync_q & ~vsync;

  if (MODE == MODE_PRIO) begin : g_prio
    layer_prio_sel #(
      .NUM_LAYERS(NUM_LAYERS),
      .COLOR_W   (COLOR_W)
    ) u_prio_sel (
      .active_i(active),
      .r_i     (layer_r),
      .g_i     (layer_g),
      .b_i     (layer_b),
      .r_o     (mix_r),
      .g_o     (mix_g),
      .b_o     (mix_b)
    );
  end else begin : g_or
    always_comb begin
      mix_r = '0;
      mix_g = '0;
      mix_b = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (active[i]) begin
          mix_r = mix_r | layer_r[i*COLOR_W +: COLOR_W];
          mix_g = mix_g | layer_g[i*COLOR_W +: COLOR_W];
          mix_b = mix_b | layer_b[i*COLOR_W +: COLOR_W];
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    boundary = 1'b0;
    unique case (state_q)
      StIdle:  if (vsync) state_d = StAccum;
      StAccum: boundary = vsync_fall;
      default: state_d = StIdle;
    endcase
  end

  // The boundary cycle's own overlap belongs to the frame being closed.
  always_comb begin
    acc_d       = acc_q;
    flags_d     = flags_q;
    tick_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    irq_d       = irq_q & ~irq_ack;
    if (boundary) begin
      flags_d     = closing;
      acc_d       = '0;
      tick_d      = 1'b1;
      frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
      if (|closing) irq_d = 1'b1;
    end else if (state_q == StAccum) begin
      acc_d = closing;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      vsync_q     <= 1'b1;
      acc_q       <= '0;
      flags_q     <= '0;
      tick_q      <= 1'b0;
      irq_q       <= 1'b0;
      frame_cnt_q <= '0;
      out_r_q     <= '0;
      out_g_q     <= '0;
      out_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= vsync;
      acc_q       <= acc_d;
      flags_q     <= flags_d;
      tick_q      <= tick_d;
      irq_q       <= irq_d;
      frame_cnt_q <= frame_cnt_d;
      out_r_q     <= mix_r;
      out_g_q     <= mix_g;
      out_b_q     <= mix_b;
    end
  end

  assign out_r      = out_r_q;
  assign out_g      = out_g_q;
  assign out_b      = out_b_q;
  assign coll_flags = flags_q;
  assign frame_tick = tick_q;
  assign coll_irq   = irq_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: doc/layer_mixer.md
LAYER_MIXER -- requirements
Module: layer_mixer

Interface
REQ-001 Parameter NUM_LAYERS, default 4, number of sprite layers (legal 2..8).
REQ-002 Parameter COLOR_W, default 8, bits per colour channel.
REQ-003 Parameter MODE, default 0, 0 = OR-blend all active layers, 1 = priority (lowest-index active layer wins).
REQ-004 Port: clk  input  1  pixel clock.
REQ-005 Port: rst  input  1  asynchronous active-low reset.
REQ-006 Port: vsync  input  1  VGA vertical sync, active-low pulse.
REQ-007 Port: layer_hit  input  NUM_LAYERS  bit i = layer i covers the current pixel.
REQ-008 Port: layer_r, layer_g, layer_b  input  NUM_LAYERS*COLOR_W each  per-layer colour, layer i at bits [i*COLOR_W +: COLOR_W].
REQ-009 Port: layer_en  input  NUM_LAYERS  per-layer display enable.
REQ-010 Port: coll_mask  input  NUM_LAYERS  per-layer collision participation enable.
REQ-011 Port: irq_ack  input  1  clears coll_irq.
REQ-012 Port: out_r, out_g, out_b  output  COLOR_W each  mixed pixel colour.
REQ-013 Port: coll_flags  output  NUM_LAYERS  per-frame collision result, bit i = layer i overlapped another participating layer.
REQ-014 Port: frame_tick  output  1  one-cycle pulse at each frame boundary.
REQ-015 Port: coll_irq  output  1  sticky collision interrupt.
REQ-016 Port: frame_cnt  output  16  frames completed since reset.

Function
REQ-017 Active set A = layer_hit AND layer_en; the mixed colour shall be registered, giving 1-cycle latency from inputs to out_r/g/b.
REQ-018 MODE 0: each output channel shall be the bitwise OR of the channel values of all layers in A; all-zero when A is empty.
REQ-019 MODE 1: each output channel shall be the value of the lowest-index layer in A; all-zero when A is empty.
REQ-020 Collision set C = layer_hit AND coll_mask, independent of layer_en; when popcount(C) >= 2, every bit of C shall be ORed into an internal accumulator in the same cycle.
REQ-021 Frame boundary = vsync falling edge, detected against a registered copy of vsync.
REQ-022 On a frame boundary cycle: coll_flags <= accumulator OR that cycle's contribution; accumulator <= 0; frame_tick = 1 for exactly that cycle; frame_cnt increments.
REQ-023 Collision on the boundary cycle shall count toward the frame being closed, not the next.
REQ-024 frame_cnt shall wrap from 16'hFFFF to 0 without other side effects.
REQ-025 coll_irq shall set on a frame boundary whose transferred coll_flags is non-zero and clear on irq_ack; simultaneous set and ack: set wins.
REQ-026 Control FSM states: IDLE (after reset, before the first vsync rising edge) -> ACCUM (on vsync high) -> ACCUM on every boundary; no accumulation and no frame_tick occur in IDLE.
REQ-027 vsync held low continuously shall generate only one boundary; glitch filtering is not required.

Reset
REQ-028 While rst = 0: out_r/g/b = 0, coll_flags = 0, frame_tick = 0, coll_irq = 0, frame_cnt = 0, accumulator = 0, registered vsync = 1, FSM = IDLE.
REQ-029 Reset mid-frame shall discard the partial accumulation; the first boundary after reset reports only collisions seen after leaving IDLE.

Structure
REQ-030 Shared package pong_pkg shall hold MODE_OR/MODE_PRIO constants, the FSM state enum and the frame-counter width.
REQ-031 One sub-module, layer_prio_sel, shall implement the lowest-index priority select in MODE 1; all other logic shall reside in layer_mixer.

Verification
REQ-032 MODE 0, NUM_LAYERS=4, layers 1 and 3 hit and enabled with r=8'h0F and r=8'hF0 -> out_r=8'hFF one cycle later.
REQ-033 MODE 1, layers 0 and 2 hit with g=8'h11 and g=8'h22, layer_en=4'b1110 -> out_g=8'h22; with layer_en=4'b1111 -> out_g=8'h11.
REQ-034 Layers 0 and 1 overlap for 3 cycles mid-frame, coll_mask=4'hF, then vsync falls -> coll_flags=4'b0011, frame_tick high for 1 cycle, coll_irq=1; the next clean frame -> coll_flags=4'b0000 while coll_irq stays 1 until irq_ack.
REQ-035 Overlap of layers 2 and 3 exactly on the vsync falling-edge cycle -> coll_flags=4'b1100 at that boundary; irq_ack asserted in the same cycle -> coll_irq=1.
REQ-036 Preload 65535 boundaries, then one more -> frame_cnt=0; assert rst mid-frame after an overlap -> all outputs 0, and the next boundary reports coll_flags=0.
